// File: rtl/irq_watchdog_timer.sv
// Periodic IRQ generator with watchdog for the Star Wars CPU board.
// Counts CPU clock enables, latches an active-low IRQ once per period and
// issues a CPU reset pulse when the watchdog is not cleared in time.
module irq_watchdog_timer #(
  parameter int unsigned PERIOD     = 12288,
  parameter int unsigned CW         = 14,
  parameter int unsigned WDOG_IRQS  = 8,
  parameter int unsigned WDOG_PULSE = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Cen,
  input  logic          Irq_ack,
  input  logic          Wdog_clr,
  output logic          Irq_n,
  output logic          Tick,
  output logic          Wdog_reset,
  output logic [CW-1:0] Count
);

  localparam int unsigned PW = (WDOG_PULSE > 1) ? $clog2(WDOG_PULSE) : 1;

  localparam logic [CW-1:0] CountLast = CW'(PERIOD - 1);
  localparam logic [3:0]    WdogLast  = 4'(WDOG_IRQS - 1);
  localparam logic [PW-1:0] PulseLast = PW'(WDOG_PULSE - 1);

  typedef enum logic {
    StRun,
    StPulse
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          irq_n_q, irq_n_d;
  logic          tick_q, tick_d;
  logic          wdog_reset_q, wdog_reset_d;
  logic [3:0]    wdog_cnt_q, wdog_cnt_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic          wrap;

  // Next-state logic for the period counter, IRQ latch, watchdog and pulse timer.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    irq_n_d      = irq_n_q;
    tick_d       = 1'b0;
    wdog_reset_d = wdog_reset_q;
    wdog_cnt_d   = wdog_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    wrap         = 1'b0;

    case (state_q)
      StRun: begin
        wrap = Cen && (count_q == CountLast);
        if (Cen) begin
          count_d = wrap ? '0 : count_q + 1'b1;
        end
        tick_d = wrap;

        // Set beats acknowledge so a coincident ack never loses an interrupt.
        if (wrap) begin
          irq_n_d = 1'b0;
        end else if (Irq_ack) begin
          irq_n_d = 1'b1;
        end

        // Clear beats a coincident wrap.
        if (Wdog_clr) begin
          wdog_cnt_d = '0;
        end else if (wrap) begin
          if (wdog_cnt_q == WdogLast) begin
            state_d      = StPulse;
            wdog_reset_d = 1'b1;
            pulse_cnt_d  = '0;
            irq_n_d      = 1'b1;
          end else begin
            wdog_cnt_d = wdog_cnt_q + 4'd1;
          end
        end
      end

      StPulse: begin
        count_d = '0;
        irq_n_d = 1'b1;
        if (Cen) begin
          if (pulse_cnt_q == PulseLast) begin
            state_d      = StRun;
            wdog_reset_d = 1'b0;
            wdog_cnt_d   = '0;
            pulse_cnt_d  = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StRun;
      count_q      <= '0;
      irq_n_q      <= 1'b1;
      tick_q       <= 1'b0;
      wdog_reset_q <= 1'b0;
      wdog_cnt_q   <= '0;
      pulse_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      irq_n_q      <= irq_n_d;
      tick_q       <= tick_d;
      wdog_reset_q <= wdog_reset_d;
      wdog_cnt_q   <= wdog_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
    end
  end

  assign Irq_n      = irq_n_q;
  assign Tick       = tick_q;
  assign Wdog_reset = wdog_reset_q;
  assign Count      = count_q;

endmodule
